// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of a small combinational
// block, holds each one for a settle interval, captures the block's outputs
// and scores them against an expected truth table.
module truth_table_sweeper #(
  parameter int NUM_IN        = 4,
  parameter int NUM_OUT       = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_OUT*(2**NUM_IN)-1:0]  exp_table,
  output logic [NUM_IN-1:0]               dut_in,
  input  logic [NUM_OUT-1:0]              dut_out,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [NUM_IN:0]                 err_count,
  output logic [NUM_IN-1:0]               first_err_idx,
  output logic [NUM_OUT*(2**NUM_IN)-1:0]  captured
);

  localparam int TW = NUM_OUT * (2**NUM_IN);
  localparam logic [NUM_IN-1:0] LAST_IDX = '1;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     exp_q;
  logic [NUM_IN-1:0] idx;
  logic [3:0]        cnt;
  logic [NUM_OUT-1:0] exp_cur;
  logic              mismatch, accept, last;

  assign exp_cur  = exp_q[idx*NUM_OUT +: NUM_OUT];
  assign mismatch = (dut_out != exp_cur);
  // abort beats a simultaneous start
  assign accept   = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign last     = (idx == LAST_IDX);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (accept) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)                 state_nxt = IDLE;
        else if (cnt == CNT_LAST)  state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (abort)      state_nxt = IDLE;
        else if (last)  state_nxt = DONE;
        else            state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sweep datapath: vector drive, settle timing, capture and scoring
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q         <= '0;
      idx           <= '0;
      cnt           <= '0;
      dut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      captured      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            exp_q         <= exp_table;
            err_count     <= '0;
            first_err_idx <= '0;
            captured      <= '0;
            pass          <= 1'b0;
            idx           <= '0;
            dut_in        <= '0;
            cnt           <= '0;
            busy          <= 1'b1;
          end
        end
        SETTLE: begin
          if (abort) begin
            busy   <= 1'b0;
            dut_in <= '0;
            pass   <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            // partial results are left visible for debug
            busy   <= 1'b0;
            dut_in <= '0;
            pass   <= 1'b0;
          end else begin
            captured[idx*NUM_OUT +: NUM_OUT] <= dut_out;
            if (mismatch) begin
              err_count <= err_count + 1'b1;
              if (err_count == '0) first_err_idx <= idx;
            end
            if (last) begin
              // the last vector's mismatch must count toward pass
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_count == '0) && !mismatch;
            end else begin
              idx    <= idx + 1'b1;
              dut_in <= idx + 1'b1;
              cnt    <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a lab circuit (f = parity, g = majority)
// with optional injected faults, scored against truth tables built here.
module tb_truth_table_sweeper;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, start1;
  logic        abort1 = 1'b0;
  logic [31:0] exp_table, exp_table1, fault;
  logic [3:0]  dut_in, dut_in1, first_err_idx, first_err_idx1;
  logic [1:0]  dut_out, dut_out1;
  logic        busy, done, pass, busy1, done1, pass1;
  logic [4:0]  err_count, err_count1;
  logic [31:0] captured, captured1;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] lab(input int i);
    logic [3:0] v;
    v = i[3:0];
    return {^v, ($countones(v) >= 3)};
  endfunction

  assign dut_out  = lab(int'(dut_in)) ^ fault[dut_in*2 +: 2];
  assign dut_out1 = lab(int'(dut_in1));

  truth_table_sweeper #(.NUM_IN(4), .NUM_OUT(2), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .exp_table(exp_table),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .captured(captured));

  truth_table_sweeper #(.NUM_IN(4), .NUM_OUT(2), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .exp_table(exp_table1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .first_err_idx(first_err_idx1), .captured(captured1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // what the circuit under test really produces, fault included
  function automatic logic [31:0] true_tab();
    logic [31:0] t;
    for (int i = 0; i < NV; i++) t[i*2 +: 2] = lab(i) ^ fault[i*2 +: 2];
    return t;
  endfunction

  function automatic logic [31:0] clean_tab();
    logic [31:0] t;
    for (int i = 0; i < NV; i++) t[i*2 +: 2] = lab(i);
    return t;
  endfunction

  // mismatches among vectors [0, upto)
  function automatic int n_err(input int upto);
    logic [31:0] t;
    int n;
    t = true_tab();
    n = 0;
    for (int i = 0; i < upto; i++) if (t[i*2 +: 2] != exp_table[i*2 +: 2]) n++;
    return n;
  endfunction

  function automatic int first_err();
    logic [31:0] t;
    t = true_tab();
    for (int i = 0; i < NV; i++) if (t[i*2 +: 2] != exp_table[i*2 +: 2]) return i;
    return 0;
  endfunction

  task automatic run_sweep(input string tag, input int restart_at);
    int n, terr;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0; terr = 0;
    while (busy && n < 200) begin
      if (dut_in !== 4'(n / 3)) terr++;
      start = (n == restart_at);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, n, 48);
    chk({tag, "_vector_trace"}, terr, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err_count"}, err_count, n_err(NV));
    chk({tag, "_first_err"}, first_err_idx, first_err());
    chk({tag, "_pass"}, pass, n_err(NV) == 0);
    chk({tag, "_captured"}, captured, true_tab());
    chk({tag, "_dut_in_hold"}, dut_in, 15);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic wait_index(input logic [3:0] v);
    int k;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (dut_in !== v && k < 200) begin k++; @(negedge clk); end
    chk("wait_index_timeout", k < 200, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    fault = '0; exp_table = clean_tab(); exp_table1 = clean_tab();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_idx, 0);
    chk("rst_captured", captured, 0);
    chk("rst_dut_in", dut_in, 0);

    // clean lab sweep, with a stray start mid-sweep that must be ignored
    run_sweep("clean", 20);

    // f of vector 5 and g of vector 12 flipped in the expectations
    exp_table = clean_tab() ^ (32'h1 << 11) ^ (32'h1 << 24);
    run_sweep("flip", -1);
    chk("flip_err2", err_count, 2);
    chk("flip_first5", first_err_idx, 5);

    // restart after DONE clears the scoreboard
    exp_table = clean_tab();
    run_sweep("rerun", -1);

    // randomized faults and expectation flips
    for (int r = 0; r < 6; r++) begin
      fault = $urandom() & $urandom();
      exp_table = clean_tab() ^ ($urandom() & $urandom() & $urandom());
      run_sweep($sformatf("rand%0d", r), -1);
    end

    // start and abort together in IDLE: abort wins
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_idle", busy, 0);

    // abort at index 7 keeps partial scoring, no done pulse
    fault = 32'h0000_5a5a;
    exp_table = clean_tab();
    wait_index(4'd7);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dut_in", dut_in, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err_partial", err_count, n_err(7));
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end

    // synchronous reset at index 9 wipes everything
    fault = '0;
    exp_table = clean_tab() ^ 32'h3;
    wait_index(4'd9);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dut_in", dut_in, 0);
    chk("rst_mid_err", err_count, 0);
    chk("rst_mid_captured", captured, 0);
    exp_table = clean_tab();
    run_sweep("after_rst", -1);

    // one-cycle settle build: 32 busy cycles
    begin
      int n;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      n = 0;
      while (busy1 && n < 200) begin n++; @(negedge clk); end
      chk("sc1_busy_cycles", n, 32);
      chk("sc1_done", done1, 1);
      chk("sc1_pass", pass1, 1);
      chk("sc1_captured", captured1, clean_tab());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
